ft600_mode_245: RTL and testbench
=================================

# ft600_mode_245

Bridge between fabric logic and an FTDI FT600 USB 3.0 chip running in 245 synchronous FIFO mode. The fabric writes 16-bit words into a TX FIFO and reads words from an RX FIFO. A single state machine moves TX words to the chip and RX words from it over the shared bidirectional data bus. The block sits at the top level, directly on the FT600 pins.

## Interface
- `RX_BUF_WIDTH`, default 3: log2 of RX FIFO depth (8 words).
- `TX_BUF_WIDTH`, default 3: log2 of TX FIFO depth (8 words).
- `clk` in 1: the only clock. It is the FT600 CLK output (100 MHz). Fabric-side ports are also synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `tx_en` in 1: TX FIFO write strobe.
- `tx_in` in 16: TX write data.
- `tx_full` out 1: TX FIFO holds 2^TX_BUF_WIDTH words.
- `rx_en` in 1: RX FIFO pop strobe.
- `rx_out` out 16: RX FIFO head. First-word-fall-through (FWFT).
- `rx_empty` out 1: RX FIFO empty.
- `ft_data` inout 16: FT600 DATA bus.
- `ft_be` inout 2: FT600 BE bus.
- `ft_txe` in 1: TXE_N, active low. Chip can accept data.
- `ft_rxf` in 1: RXF_N, active low. Chip has data.
- `ft_oe` out 1: OE_N, active low.
- `ft_rd` out 1: RD_N, active low.
- `ft_wr` out 1: WR_N, active low.

## Operation
- **FIFOs**
  - Both FIFOs are FWFT.
  - A write while full is dropped. A pop while empty is ignored; `rx_out` holds.
  - A simultaneous push and pop in one cycle is legal.
- **States:** IDLE, TX, RX_OE, RX_READ, RX_END.
- **IDLE**
  - All strobes are high; `ft_data` and `ft_be` are high-Z.
  - RX request: `ft_rxf`=0 and RX FIFO free space >= 2.
  - TX request: `ft_txe`=0 and TX FIFO not empty.
  - RX wins if both are requested in the same cycle.
- **TX**
  - Drive `ft_data` = TX head and `ft_be` = 2'b11.
  - A word is transferred on every edge where `ft_wr`=0 and `ft_txe`=0 at that edge. Each transfer pops the TX FIFO.
  - `ft_wr` for the next cycle = 0 iff FIFO is non-empty after this pop and `ft_txe`=0.
  - Otherwise return to IDLE and release the bus.
  - A word presented while `ft_txe` is high is not popped and is re-sent later. No loss, no duplicates.
- **RX_OE**
  - `ft_oe`=0, FPGA bus drivers off. Stay one cycle.
- **RX_READ**
  - `ft_rd`=0. Push `ft_data` into the RX FIFO on every edge where `ft_rd`=0 and `ft_rxf`=0.
  - `ft_rd` stays low iff `ft_rxf`=0 and free space after this push is >= 2. Otherwise go to RX_END.
  - `ft_be` is ignored; data is stored as-is.
- **RX_END**
  - `ft_rd`=1, `ft_oe`=1, for one cycle (turnaround), then IDLE.
- **Reset**
  - Both FIFOs are flushed and the state returns to IDLE on the next edge, including mid-burst.
  - Reset values: `ft_oe`, `ft_rd`, `ft_wr` = 1; buses high-Z; `tx_full`=0; `rx_empty`=1; `rx_out`=0.

## Timing
- All strobe outputs are registered.
- `tx_en` at edge N, FIFO previously empty, `ft_txe`=0: the word is on `ft_data` with `ft_wr`=0 after edge N+1.
- Sustained throughput: 1 word per clk in either direction.
- Direction change: at least one IDLE cycle with the bus released. RX additionally costs the RX_OE and RX_END cycles.
- Flags update on the edge after the causing write or pop. `tx_full` is asserted after the 8th write with no pops.

## Configuration
- `FT600_RX_EN` defined: full RX path as described above.
- `FT600_RX_EN` undefined:
  - RX FIFO and RX states are removed.
  - `ft_oe` and `ft_rd` are tied high; `rx_empty`=1; `rx_out`=0.
  - `rx_en` and `ft_rxf` are ignored.

## Structure
- Package `ft600_pkg`: state enum, `FT_DATA_W`=16, `FT_BE_W`=2, `BE_ALL`=2'b11.
- One sub-module, `ft600_fifo`: parameterised synchronous FWFT FIFO with full/empty flags. Instanced for TX and RX.
- Bench-side `count_feeder` (outside this block) writes an incrementing 16-bit counter whenever `tx_full`=0.

## Test plan
- **Reset:** hold `rst` 100 cycles with `ft_txe`=`ft_rxf`=1 -> strobes all 1, buses Z, `tx_full`=0, `rx_empty`=1.
- **TX stream:** `count_feeder` running, `ft_txe`=0 for 1000 cycles -> `ft_data` shows 0000, 0001, … on consecutive `ft_wr`=0 edges, no gaps or repeats, `ft_be`=11.
- **TX stall:** `ft_txe` high 100 cycles then 30-cycle low pulse -> sequence resumes exactly after the last accepted value; `ft_wr`=1 while `ft_txe`=1.
- **TX full:** `ft_txe`=1, 10 writes -> `tx_full`=1 after 8; writes 9 and 10 dropped; `ft_txe`=0 -> exactly 8 words sent.
- **RX burst:** `ft_rxf`=0 with words A000..A005 -> `ft_oe` low one cycle before `ft_rd`; RX FIFO yields A000..A005 in order via `rx_en`.
- **Arbitration:** `ft_rxf`=0 and `ft_txe`=0 with TX data pending -> RX served first; TX follows after RX_END and one IDLE cycle, with no bus contention.

Source files
------------

// File: rtl/ft600_pkg.sv
// ft600_pkg: shared types and constants for the FT600 245-mode bridge.
package ft600_pkg;

    localparam int FT_DATA_W = 16;
    localparam int FT_BE_W   = 2;
    localparam logic [FT_BE_W-1:0] BE_ALL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_RX_OE,
        ST_RX_READ,
        ST_RX_END
    } ft_state_e;

endpackage

// File: rtl/ft600_fifo.sv
// ft600_fifo: synchronous first-word-fall-through FIFO. The head word is
// visible on rd_data while empty is low; rd_data reads zero when empty.
module ft600_fifo #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_W);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ONE_W;
            if (rd_ok) rd_ptr <= rd_ptr + ONE_W;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ft600_mode_245.sv
// ft600_mode_245: fabric FIFOs bridged onto FT600 245 synchronous FIFO pins.
// Define FT600_RX_EN to build the RX path; without it the block is TX-only.
module ft600_mode_245
    import ft600_pkg::*;
#(
    parameter int RX_BUF_WIDTH = 3,
    parameter int TX_BUF_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [FT_DATA_W-1:0] tx_in,
    output logic                 tx_full,
    input  logic                 rx_en,
    output logic [FT_DATA_W-1:0] rx_out,
    output logic                 rx_empty,
    inout  wire  [FT_DATA_W-1:0] ft_data,
    inout  wire  [FT_BE_W-1:0]   ft_be,
    input  logic                 ft_txe,
    input  logic                 ft_rxf,
    output logic                 ft_oe,
    output logic                 ft_rd,
    output logic                 ft_wr
);

    ft_state_e state_q, state_d;
    logic      wr_n_q, wr_n_d;
    logic      rd_n_q, rd_n_d;
    logic      oe_n_q, oe_n_d;

    logic [FT_DATA_W-1:0]  tx_head;
    logic                  tx_empty;
    logic [TX_BUF_WIDTH:0] tx_count;
    logic [TX_BUF_WIDTH:0] tx_left;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  rx_req;
    logic                  unused_pins;

    assign tx_push = tx_en && !tx_full;
    assign tx_pop  = (state_q == ST_TX) && !wr_n_q && !ft_txe;
    // Words still queued after this edge, counting a same-cycle fabric write.
    assign tx_left = tx_count - (TX_BUF_WIDTH+1)'(tx_pop) + (TX_BUF_WIDTH+1)'(tx_push);

    ft600_fifo #(.AW(TX_BUF_WIDTH), .DW(FT_DATA_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_en),
        .wr_data (tx_in),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

`ifdef FT600_RX_EN
    localparam logic [RX_BUF_WIDTH:0] RX_DEPTH = (RX_BUF_WIDTH+1)'(1 << RX_BUF_WIDTH);
    localparam logic [RX_BUF_WIDTH:0] RX_TWO   = (RX_BUF_WIDTH+1)'(2);

    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic [RX_BUF_WIDTH:0] rx_count;
    logic [RX_BUF_WIDTH:0] rx_free;
    logic [RX_BUF_WIDTH:0] rx_free_next;

    assign rx_push      = (state_q == ST_RX_READ) && !rd_n_q && !ft_rxf;
    assign rx_pop       = rx_en && !rx_empty;
    assign rx_free      = RX_DEPTH - rx_count;
    assign rx_free_next = rx_free - (RX_BUF_WIDTH+1)'(rx_push) + (RX_BUF_WIDTH+1)'(rx_pop);
    // Two free slots guarantee the word already in flight when RD_N rises fits.
    assign rx_req       = !ft_rxf && (rx_free >= RX_TWO);
    assign unused_pins  = ^{ft_be, rx_full};

    ft600_fifo #(.AW(RX_BUF_WIDTH), .DW(FT_DATA_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (ft_data),
        .rd_en   (rx_en),
        .rd_data (rx_out),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );
`else
    assign rx_req      = 1'b0;
    assign rx_empty    = 1'b1;
    assign rx_out      = '0;
    assign unused_pins = ^{ft_be, ft_data, rx_en, ft_rxf};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (rx_req) begin
                    state_d = ST_RX_OE;
                    oe_n_d  = 1'b0;
                end else if (!ft_txe && !tx_empty) begin
                    state_d = ST_TX;
                    wr_n_d  = 1'b0;
                end
            end
            ST_TX: begin
                if (!ft_txe && (tx_left != '0)) wr_n_d = 1'b0;
                else                            state_d = ST_IDLE;
            end
`ifdef FT600_RX_EN
            ST_RX_OE: begin
                state_d = ST_RX_READ;
                oe_n_d  = 1'b0;
                rd_n_d  = 1'b0;
            end
            ST_RX_READ: begin
                if (!ft_rxf && (rx_free_next >= RX_TWO)) begin
                    oe_n_d = 1'b0;
                    rd_n_d = 1'b0;
                end else begin
                    state_d = ST_RX_END;
                end
            end
            ST_RX_END: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign ft_wr   = wr_n_q;
    assign ft_rd   = rd_n_q;
    assign ft_oe   = oe_n_q;
    assign ft_data = (state_q == ST_TX) ? tx_head : {FT_DATA_W{1'bz}};
    assign ft_be   = (state_q == ST_TX) ? BE_ALL  : {FT_BE_W{1'bz}};

endmodule

// File: tb/tb_ft600_mode_245.sv
// tb_ft600_mode_245: randomized bench for the FT600 245 bridge with a
// queue-based model of the fabric FIFOs and the chip side of the bus.
module tb_ft600_mode_245;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] tx_in = '0;
  logic        rx_en = 1'b0;
  logic        ft_txe = 1'b1;
  logic        ft_rxf = 1'b1;
  logic        tx_full, rx_empty, ft_oe, ft_rd, ft_wr;
  logic [15:0] rx_out;
  wire  [15:0] ft_data;
  wire  [1:0]  ft_be;
  logic [15:0] chip_word = '0;

  // chip side: drives the bus only while OE_N is low
  assign ft_data = ft_oe ? 16'hzzzz : chip_word;
  assign ft_be   = ft_oe ? 2'bzz : 2'b11;

  always #5 clk = ~clk;

  ft600_mode_245 dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_in(tx_in), .tx_full(tx_full),
    .rx_en(rx_en), .rx_out(rx_out), .rx_empty(rx_empty),
    .ft_data(ft_data), .ft_be(ft_be), .ft_txe(ft_txe), .ft_rxf(ft_rxf),
    .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr)
  );

`ifdef FT600_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [15:0] chip_q[$];

  logic        txe_n = 1'b1;
  logic        rx_allow = 1'b0;
  logic        feed_on = 1'b0;
  int          pop_mode = 0;
  logic [15:0] feed_cnt = '0;
  int          tx_sent = 0;
  int          rx_got = 0;
  int          cyc = 0;
  logic [15:0] last_sent = '0;
  logic        prev_txe = 1'b1;
  logic        prev_rd = 1'b1;
  logic        prev_oe = 1'b1;
  int          last_oe_cyc = -100;
  int          first_wr_cyc = -1;

  // One clock of driving plus scoreboard update. Inputs are applied on the
  // falling edge; everything seen here is what the next rising edge samples.
  task automatic cycle(input logic wr, input logic [15:0] word);
    int pre_tx;
    int pre_rx;
    @(negedge clk);
    ft_txe    = txe_n;
    ft_rxf    = (rx_allow && chip_q.size() != 0) ? 1'b0 : 1'b1;
    chip_word = (chip_q.size() != 0) ? chip_q[0] : 16'h0;
    tx_en     = feed_on ? !tx_full : wr;
    tx_in     = feed_on ? feed_cnt : word;
    case (pop_mode)
      0: rx_en = 1'b0;
      1: rx_en = 1'b1;
      default: rx_en = 1'($urandom_range(0, 1));
    endcase
    #1;
    pre_tx = txq.size();
    pre_rx = rxq.size();

    n_checks++;
    if (tx_full !== (pre_tx == 8))
      $display("FAIL tx_full: got %b expected %b (cycle %0d)", tx_full, (pre_tx == 8), cyc);
    else n_pass++;
    n_checks++;
    if (rx_empty !== (pre_rx == 0))
      $display("FAIL rx_empty: got %b expected %b (cycle %0d)", rx_empty, (pre_rx == 0), cyc);
    else n_pass++;
    if (pre_rx != 0) begin
      n_checks++;
      if (rx_out !== rxq[0]) $display("FAIL rx_out: got %h expected %h", rx_out, rxq[0]);
      else n_pass++;
    end
    if (ft_wr === 1'b0) begin
      n_checks++;
      if (ft_oe !== 1'b1) $display("FAIL bus_contention: ft_oe %b while ft_wr low", ft_oe);
      else n_pass++;
    end
    if (prev_txe) begin
      n_checks++;
      if (ft_wr !== 1'b1) $display("FAIL wr_while_txe_high: ft_wr got %b expected 1", ft_wr);
      else n_pass++;
    end
    if (ft_rd === 1'b0 && prev_rd === 1'b1) begin
      n_checks++;
      if (prev_oe !== 1'b0) $display("FAIL oe_before_rd: prior ft_oe got %b expected 0", prev_oe);
      else n_pass++;
    end

    if (ft_wr === 1'b0 && ft_txe === 1'b0) begin
      n_checks++;
      if (pre_tx == 0) begin
        $display("FAIL tx_extra: got word %h, expected none pending", ft_data);
      end else begin
        if (ft_data !== txq[0] || ft_be !== 2'b11)
          $display("FAIL tx_data: got %h/%b expected %h/11", ft_data, ft_be, txq[0]);
        else n_pass++;
        last_sent = txq.pop_front();
      end
      tx_sent++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (ft_oe === 1'b0) last_oe_cyc = cyc;
    if (tx_en && pre_tx < 8) txq.push_back(tx_in);
    if (feed_on && tx_en) feed_cnt++;

    if (rx_en && pre_rx != 0) void'(rxq.pop_front());
    if (ft_rd === 1'b0 && ft_rxf === 1'b0) begin
      n_checks++;
      if (pre_rx >= 8) $display("FAIL rx_overflow: got read with %0d words held, expected at most 7", pre_rx);
      else n_pass++;
      rxq.push_back(chip_q.pop_front());
      rx_got++;
    end

    prev_txe = ft_txe;
    prev_rd  = ft_rd;
    prev_oe  = ft_oe;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; tx_en = 1'b0; rx_en = 1'b0; ft_txe = 1'b1; ft_rxf = 1'b1;
    feed_on = 1'b0; txe_n = 1'b1; rx_allow = 1'b0; pop_mode = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    txq.delete(); rxq.delete(); chip_q.delete();
    prev_txe = 1'b1; prev_rd = 1'b1; prev_oe = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(100);
    n_checks++; if (ft_oe !== 1'b1) $display("FAIL reset_oe: got %b expected 1", ft_oe); else n_pass++;
    n_checks++; if (ft_rd !== 1'b1) $display("FAIL reset_rd: got %b expected 1", ft_rd); else n_pass++;
    n_checks++; if (ft_wr !== 1'b1) $display("FAIL reset_wr: got %b expected 1", ft_wr); else n_pass++;
    n_checks++; if (tx_full !== 1'b0) $display("FAIL reset_tx_full: got %b expected 0", tx_full); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); else n_pass++;
    n_checks++; if (rx_out !== 16'h0) $display("FAIL reset_rx_out: got %h expected 0000", rx_out); else n_pass++;
  endtask

  task automatic test_latency();
    do_reset(2);
    txe_n = 1'b0;
    cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h5A5A);
    cycle(1'b0, 16'h0);
    n_checks++; if (ft_wr !== 1'b1) $display("FAIL latency_n1: ft_wr got %b expected 1", ft_wr); else n_pass++;
    cycle(1'b0, 16'h0);
    n_checks++;
    if (ft_wr !== 1'b0 || ft_data !== 16'h5A5A)
      $display("FAIL latency_n2: got wr=%b data=%h expected wr=0 data=5a5a", ft_wr, ft_data);
    else n_pass++;
    repeat (4) cycle(1'b0, 16'h0);
  endtask

  task automatic test_tx_stream();
    int sent0;
    do_reset(2);
    feed_cnt = '0; feed_on = 1'b1; txe_n = 1'b0; sent0 = tx_sent;
    repeat (1000) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent - sent0 < 995) $display("FAIL tx_throughput: got %0d words expected >= 995", tx_sent - sent0);
    else n_pass++;
    feed_on = 1'b0;
    for (int i = 0; i < 40 && txq.size() != 0; i++) cycle(1'b0, 16'h0);
    n_checks++;
    if (txq.size() != 0 || last_sent !== feed_cnt - 16'd1)
      $display("FAIL tx_stream_drain: last %h pending %0d expected last %h pending 0", last_sent, txq.size(), feed_cnt - 16'd1);
    else n_pass++;
  endtask

  task automatic test_tx_stall();
    int sent0;
    do_reset(2);
    feed_cnt = '0; feed_on = 1'b1; txe_n = 1'b0;
    repeat (40) cycle(1'b0, 16'h0);
    txe_n = 1'b1; sent0 = tx_sent;
    repeat (100) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent != sent0) $display("FAIL tx_stall_hold: got %0d words expected 0", tx_sent - sent0);
    else n_pass++;
    txe_n = 1'b0;
    repeat (30) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent - sent0 < 26) $display("FAIL tx_stall_resume: got %0d words expected >= 26", tx_sent - sent0);
    else n_pass++;
    feed_on = 1'b0;
    for (int i = 0; i < 40 && txq.size() != 0; i++) cycle(1'b0, 16'h0);
  endtask

  task automatic test_tx_full();
    int sent0;
    do_reset(2);
    txe_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'hB000 + 16'(i));
    cycle(1'b0, 16'h0);
    n_checks++; if (tx_full !== 1'b1) $display("FAIL tx_full_after8: got %b expected 1", tx_full); else n_pass++;
    txe_n = 1'b0; sent0 = tx_sent;
    repeat (20) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent - sent0 != 8 || last_sent !== 16'hB007)
      $display("FAIL tx_full_sent: got %0d words last %h expected 8 last b007", tx_sent - sent0, last_sent);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int sent0;
    do_reset(2);
    feed_cnt = '0; feed_on = 1'b1; txe_n = 1'b0;
    repeat (20) cycle(1'b0, 16'h0);
    do_reset(2);
    n_checks++;
    if (ft_wr !== 1'b1 || tx_full !== 1'b0)
      $display("FAIL mid_reset: got wr=%b full=%b expected wr=1 full=0", ft_wr, tx_full);
    else n_pass++;
    txe_n = 1'b0; sent0 = tx_sent;
    repeat (10) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent != sent0) $display("FAIL mid_reset_flush: got %0d words expected 0", tx_sent - sent0);
    else n_pass++;
  endtask

  task automatic test_rx_burst();
    int got0;
    do_reset(2);
    for (int i = 0; i < 6; i++) chip_q.push_back(16'hA000 + 16'(i));
    rx_allow = 1'b1; got0 = rx_got; last_oe_cyc = -100;
    repeat (20) cycle(1'b0, 16'h0);
`ifdef FT600_RX_EN
    n_checks++;
    if (rx_got - got0 != 6) $display("FAIL rx_burst_count: got %0d words expected 6", rx_got - got0);
    else n_pass++;
    pop_mode = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0);
      n_checks++;
      if (rx_out !== 16'hA000 + 16'(i)) $display("FAIL rx_burst_order: got %h expected %h", rx_out, 16'hA000 + 16'(i));
      else n_pass++;
    end
    pop_mode = 0;
    cycle(1'b0, 16'h0);
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL rx_burst_empty: got %b expected 1", rx_empty); else n_pass++;
`else
    n_checks++;
    if (rx_got != got0 || last_oe_cyc != -100 || rx_empty !== 1'b1)
      $display("FAIL rx_disabled: got reads=%0d oe_seen=%0d rx_empty=%b expected 0/-100/1", rx_got - got0, last_oe_cyc, rx_empty);
    else n_pass++;
`endif
  endtask

  task automatic test_rx_full();
    do_reset(2);
    for (int i = 0; i < 10; i++) chip_q.push_back(16'($urandom));
    rx_allow = 1'b1; rx_got = 0;
    repeat (30) cycle(1'b0, 16'h0);
    n_checks++;
    if (rx_got != (RX_ON ? 7 : 0)) $display("FAIL rx_full_stop: got %0d words expected %0d", rx_got, RX_ON ? 7 : 0);
    else n_pass++;
    pop_mode = 1;
    cycle(1'b0, 16'h0);
    pop_mode = 0;
    repeat (20) cycle(1'b0, 16'h0);
    n_checks++;
    if (rx_got != (RX_ON ? 8 : 0) || rxq.size() != (RX_ON ? 7 : 0))
      $display("FAIL rx_full_refill: got %0d read %0d held expected %0d/%0d", rx_got, rxq.size(), RX_ON ? 8 : 0, RX_ON ? 7 : 0);
    else n_pass++;
    pop_mode = 1;
    repeat (40) cycle(1'b0, 16'h0);
    n_checks++;
    if (rx_got != (RX_ON ? 10 : 0) || rxq.size() != 0)
      $display("FAIL rx_full_drain: got %0d read %0d held expected %0d/0", rx_got, rxq.size(), RX_ON ? 10 : 0);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int sent0;
    do_reset(2);
    txe_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'hC000 + 16'(i));
    for (int i = 0; i < 3; i++) chip_q.push_back(16'hD000 + 16'(i));
    first_wr_cyc = -1; last_oe_cyc = -100; rx_got = 0; sent0 = tx_sent;
    txe_n = 1'b0; rx_allow = 1'b1;
    repeat (30) cycle(1'b0, 16'h0);
    n_checks++;
    if (tx_sent - sent0 != 4) $display("FAIL arb_tx_sent: got %0d expected 4", tx_sent - sent0);
    else n_pass++;
`ifdef FT600_RX_EN
    n_checks++;
    if (rx_got != 3 || first_wr_cyc - last_oe_cyc != 3)
      $display("FAIL arb_order: got rx=%0d gap=%0d expected rx=3 gap=3", rx_got, first_wr_cyc - last_oe_cyc);
    else n_pass++;
`else
    n_checks++;
    if (rx_got != 0 || last_oe_cyc != -100)
      $display("FAIL arb_tx_only: got rx=%0d oe_seen=%0d expected 0/-100", rx_got, last_oe_cyc);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int sent0;
    int got0;
    do_reset(2);
    feed_cnt = '0; feed_on = 1'b1; pop_mode = 2; sent0 = tx_sent; got0 = rx_got;
    for (int i = 0; i < 800; i++) begin
      txe_n = ($urandom_range(0, 3) == 0);
      rx_allow = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) chip_q.push_back(16'($urandom));
      cycle(1'b0, 16'h0);
    end
    feed_on = 1'b0; txe_n = 1'b0; rx_allow = 1'b1; pop_mode = 1;
    for (int i = 0; i < 300 && (txq.size() != 0 || rxq.size() != 0 || (RX_ON && chip_q.size() != 0)); i++)
      cycle(1'b0, 16'h0);
    n_checks++;
    if (txq.size() != 0 || rxq.size() != 0 || (RX_ON && chip_q.size() != 0))
      $display("FAIL random_drain: got tx=%0d rx=%0d chip=%0d pending expected none", txq.size(), rxq.size(), chip_q.size());
    else n_pass++;
    n_checks++;
    if (tx_sent == sent0 || (RX_ON && rx_got == got0))
      $display("FAIL random_activity: got tx=%0d rx=%0d transfers expected nonzero", tx_sent - sent0, rx_got - got0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tx_stream();
    test_tx_stall();
    test_tx_full();
    test_reset_mid_burst();
    test_rx_burst();
    test_rx_full();
    test_arbitration();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
